// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing source for the demo pipeline.
//
// Produces the pixel-step enable, the beam position (x, y), the active-video
// flag, the active-low sync pulses, the line and frame strobes, and a
// completed-frame counter. The enable is either every clock (FULL_FPS=1) or
// every other clock (FULL_FPS=0); counters move only on enable cycles.
//
// Ports:
//   clk          in   clock
//   reset        in   synchronous, active-high reset
//   enable       out  pixel-step strobe
//   x, y         out  beam position (10 bit each)
//   active       out  x < H_ACTIVE and y < V_ACTIVE
//   hsync, vsync out  active-low sync pulses
//   new_line     out  one-clock pulse when x wraps to 0
//   new_frame    out  one-clock pulse when (x, y) wraps to (0, 0)
//   frame_count  out  frames completed since reset, modulo 256
//
// Optional feature, macro VGA_TIMING_LOOKAHEAD_EN:
//   x_next, y_next, active_next  out  values x, y, active take at the next step
//
// All outputs are registered. Sync and active flags are decoded from the
// next-state position so they line up with the x, y presented in that cycle.

module vga_timing_gen #(
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33,
   parameter int unsigned FULL_FPS = 1
) (
   input  logic       clk,
   input  logic       reset,
   output logic       enable,
   output logic [9:0] x,
   output logic [9:0] y,
   output logic       active,
   output logic       hsync,
   output logic       vsync,
   output logic       new_line,
   output logic       new_frame,
   output logic [7:0] frame_count
`ifdef VGA_TIMING_LOOKAHEAD_EN
   ,
   output logic [9:0] x_next,
   output logic [9:0] y_next,
   output logic       active_next
`endif
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam bit          HALF_RATE = (FULL_FPS == 0);

   localparam logic [9:0]  H_LAST  = 10'(H_TOTAL - 1);
   localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);
   // 11-bit bounds so a region ending exactly at 1024 still compares correctly
   localparam logic [10:0] H_ACT_W = 11'(H_ACTIVE);
   localparam logic [10:0] V_ACT_W = 11'(V_ACTIVE);
   localparam logic [10:0] HS_BEG  = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] HS_END  = 11'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [10:0] VS_BEG  = 11'(V_ACTIVE + V_FP);
   localparam logic [10:0] VS_END  = 11'(V_ACTIVE + V_FP + V_SYNC);

   // Elaboration-time parameter sanity check
   generate
      if (H_TOTAL > 1024 || V_TOTAL > 1024 || H_TOTAL < 2 || V_TOTAL < 1 ||
          H_ACTIVE < 1 || V_ACTIVE < 1 || FULL_FPS > 1) begin : g_param_check
         $error("vga_timing_gen: illegal timing parameters");
      end
   endgenerate

   function automatic logic [9:0] step_x(input logic [9:0] xc);
      return (xc == H_LAST) ? 10'd0 : xc + 10'd1;
   endfunction

   function automatic logic [9:0] step_y(input logic [9:0] xc, input logic [9:0] yc);
      if (xc != H_LAST) return yc;
      return (yc == V_LAST) ? 10'd0 : yc + 10'd1;
   endfunction

   function automatic logic is_active(input logic [9:0] xc, input logic [9:0] yc);
      return ({1'b0, xc} < H_ACT_W) && ({1'b0, yc} < V_ACT_W);
   endfunction

   function automatic logic hsync_level(input logic [9:0] xc);
      return !(({1'b0, xc} >= HS_BEG) && ({1'b0, xc} < HS_END));
   endfunction

   function automatic logic vsync_level(input logic [9:0] yc);
      return !(({1'b0, yc} >= VS_BEG) && ({1'b0, yc} < VS_END));
   endfunction

   logic       enable_q, enable_d;
   logic       phase_q, phase_d;
   logic [9:0] x_q, x_d;
   logic [9:0] y_q, y_d;
   logic       active_q, active_d;
   logic       hsync_q, hsync_d;
   logic       vsync_q, vsync_d;
   logic       new_line_q, new_line_d;
   logic       new_frame_q, new_frame_d;
   logic [7:0] frame_cnt_q, frame_cnt_d;
   logic       line_wrap, frame_wrap;

   // Next-state decode: step on enable, derive flags from the new position
   always_comb begin
      x_d         = x_q;
      y_d         = y_q;
      line_wrap   = 1'b0;
      frame_wrap  = 1'b0;
      frame_cnt_d = frame_cnt_q;

      // enable goes high on the first post-reset cycle in both rates
      phase_d  = HALF_RATE ? ~phase_q : 1'b0;
      enable_d = HALF_RATE ? ~phase_q : 1'b1;

      if (enable_q) begin
         x_d        = step_x(x_q);
         y_d        = step_y(x_q, y_q);
         line_wrap  = (x_q == H_LAST);
         frame_wrap = line_wrap && (y_q == V_LAST);
      end

      if (frame_wrap) frame_cnt_d = frame_cnt_q + 8'd1;

      active_d    = is_active(x_d, y_d);
      hsync_d     = hsync_level(x_d);
      vsync_d     = vsync_level(y_d);
      new_line_d  = line_wrap;
      new_frame_d = frame_wrap;
   end

   // Timing state registers
   always_ff @(posedge clk) begin
      if (reset) begin
         enable_q    <= 1'b0;
         phase_q     <= 1'b0;
         x_q         <= 10'd0;
         y_q         <= 10'd0;
         active_q    <= 1'b1;
         hsync_q     <= 1'b1;
         vsync_q     <= 1'b1;
         new_line_q  <= 1'b0;
         new_frame_q <= 1'b0;
         frame_cnt_q <= 8'd0;
      end else begin
         enable_q    <= enable_d;
         phase_q     <= phase_d;
         x_q         <= x_d;
         y_q         <= y_d;
         active_q    <= active_d;
         hsync_q     <= hsync_d;
         vsync_q     <= vsync_d;
         new_line_q  <= new_line_d;
         new_frame_q <= new_frame_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign enable      = enable_q;
   assign x           = x_q;
   assign y           = y_q;
   assign active      = active_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign new_line    = new_line_q;
   assign new_frame   = new_frame_q;
   assign frame_count = frame_cnt_q;

`ifdef VGA_TIMING_LOOKAHEAD_EN
   logic [9:0] xn_q, xn_d;
   logic [9:0] yn_q, yn_d;
   logic       an_q, an_d;

   // Lookahead is always one step past the next-state position; while x_d
   // holds, this recomputes the same value it already holds.
   always_comb begin
      xn_d = step_x(x_d);
      yn_d = step_y(x_d, y_d);
      an_d = is_active(xn_d, yn_d);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         xn_q <= 10'd1;
         yn_q <= 10'd0;
         an_q <= 1'b1;
      end else begin
         xn_q <= xn_d;
         yn_q <= yn_d;
         an_q <= an_d;
      end
   end

   assign x_next      = xn_q;
   assign y_next      = yn_q;
   assign active_next = an_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

   // Reduced raster for frame-level checks (12 x 7)
   localparam int SHA = 8, SHF = 1, SHS = 2, SHB = 1;
   localparam int SVA = 4, SVF = 1, SVS = 1, SVB = 1;

   typedef struct packed {
      logic       en;
      logic [9:0] x;
      logic [9:0] y;
      logic       act;
      logic       hs;
      logic       vs;
      logic       nl;
      logic       nf;
      logic [7:0] fc;
      logic [9:0] xn;
      logic [9:0] yn;
      logic       an;
   } obs_t;

   typedef struct {
      int         k;   // -1 selects the in-reset cycles
      logic       en;
      logic [9:0] x;
      logic [9:0] y;
      logic       act;
      logic       hs;
      logic       vs;
      logic       nl;
      logic       nf;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_def = 1'b1, rst_sm = 1'b1, rst_hf = 1'b1;

   logic       d_en, d_act, d_hs, d_vs, d_nl, d_nf;
   logic [9:0] d_x, d_y;
   logic [7:0] d_fc;
   logic       s_en, s_act, s_hs, s_vs, s_nl, s_nf;
   logic [9:0] s_x, s_y;
   logic [7:0] s_fc;
   logic       h_en, h_act, h_hs, h_vs, h_nl, h_nf;
   logic [9:0] h_x, h_y;
   logic [7:0] h_fc;
   logic [9:0] d_xn, d_yn, s_xn, s_yn, h_xn, h_yn;
   logic       d_an, s_an, h_an;

   vga_timing_gen u_def (
      .clk(clk), .reset(rst_def), .enable(d_en), .x(d_x), .y(d_y),
      .active(d_act), .hsync(d_hs), .vsync(d_vs), .new_line(d_nl),
      .new_frame(d_nf), .frame_count(d_fc)
`ifdef VGA_TIMING_LOOKAHEAD_EN
      , .x_next(d_xn), .y_next(d_yn), .active_next(d_an)
`endif
   );

   vga_timing_gen #(
      .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
      .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB), .FULL_FPS(1)
   ) u_small (
      .clk(clk), .reset(rst_sm), .enable(s_en), .x(s_x), .y(s_y),
      .active(s_act), .hsync(s_hs), .vsync(s_vs), .new_line(s_nl),
      .new_frame(s_nf), .frame_count(s_fc)
`ifdef VGA_TIMING_LOOKAHEAD_EN
      , .x_next(s_xn), .y_next(s_yn), .active_next(s_an)
`endif
   );

   vga_timing_gen #(
      .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
      .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB), .FULL_FPS(0)
   ) u_half (
      .clk(clk), .reset(rst_hf), .enable(h_en), .x(h_x), .y(h_y),
      .active(h_act), .hsync(h_hs), .vsync(h_vs), .new_line(h_nl),
      .new_frame(h_nf), .frame_count(h_fc)
`ifdef VGA_TIMING_LOOKAHEAD_EN
      , .x_next(h_xn), .y_next(h_yn), .active_next(h_an)
`endif
   );

`ifndef VGA_TIMING_LOOKAHEAD_EN
   assign {d_xn, d_yn, d_an} = '0;
   assign {s_xn, s_yn, s_an} = '0;
   assign {h_xn, h_yn, h_an} = '0;
`endif

   obs_t o_def, o_sm, o_hf;
   assign o_def = {d_en, d_x, d_y, d_act, d_hs, d_vs, d_nl, d_nf, d_fc, d_xn, d_yn, d_an};
   assign o_sm  = {s_en, s_x, s_y, s_act, s_hs, s_vs, s_nl, s_nf, s_fc, s_xn, s_yn, s_an};
   assign o_hf  = {h_en, h_x, h_y, h_act, h_hs, h_vs, h_nl, h_nf, h_fc, h_xn, h_yn, h_an};

   int   checks = 0;
   int   failures = 0;
   vec_t tbl[12];

   // Reference: everything follows from the number of pixel steps taken since
   // reset release, k being clocks since release (k=0 is the first cycle).
   function automatic obs_t model(input int ha, input int hf, input int hsw, input int hb,
                                  input int va, input int vf, input int vsw, input int vb,
                                  input bit full, input bit rst, input int k);
      obs_t o;
      int ht, vt, steps, px, line, py, nx, ny;
      bit first;
      ht = ha + hf + hsw + hb;
      vt = va + vf + vsw + vb;
      if (rst) begin
         steps = 0; first = 1'b0; o.en = 1'b0;
      end else begin
         steps = full ? k : (k + 1) / 2;
         first = full ? (k > 0) : (k % 2 == 1);
         o.en  = full ? 1'b1 : (k % 2 == 0);
      end
      px   = steps % ht;
      line = steps / ht;
      py   = line % vt;
      o.x   = 10'(px);
      o.y   = 10'(py);
      o.act = (px < ha) && (py < va);
      o.hs  = !((px >= ha + hf) && (px < ha + hf + hsw));
      o.vs  = !((py >= va + vf) && (py < va + vf + vsw));
      o.nl  = first && (px == 0);
      o.nf  = first && (px == 0) && (py == 0);
      o.fc  = 8'((line / vt) % 256);
`ifdef VGA_TIMING_LOOKAHEAD_EN
      nx   = (steps + 1) % ht;
      ny   = ((steps + 1) / ht) % vt;
      o.xn = 10'(nx);
      o.yn = 10'(ny);
      o.an = (nx < ha) && (ny < va);
`else
      nx = 0; ny = 0;
      o.xn = 10'd0; o.yn = 10'd0; o.an = 1'b0;
`endif
      return o;
   endfunction

   task automatic finish_tb();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   endtask

   task automatic check_obs(input string name, input int k, input obs_t got, input obs_t exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s k=%0d got=%h exp=%h", name, k, got, exp);
      end
   endtask

   task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Per-instance model bookkeeping: seen-reset, in-reset, cycles since release
   bit v[3];
   bit r[3];
   int kk[3];
   int hs_low = 0;

   always begin
      logic [2:0] rv;
      @(posedge clk);
      rv = {rst_hf, rst_sm, rst_def};
      for (int i = 0; i < 3; i++) begin
         if (rv[i]) begin
            v[i] = 1'b1; r[i] = 1'b1; kk[i] = 0;
         end else if (r[i]) begin
            r[i] = 1'b0; kk[i] = 0;
         end else begin
            kk[i]++;
         end
      end
      #1;
      if (v[0]) check_obs("u_def", kk[0], o_def,
                          model(640, 16, 96, 48, 480, 10, 2, 33, 1'b1, r[0], kk[0]));
      if (v[1]) check_obs("u_small", kk[1], o_sm,
                          model(SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB, 1'b1, r[1], kk[1]));
      if (v[2]) check_obs("u_half", kk[2], o_hf,
                          model(SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB, 1'b0, r[2], kk[2]));
      // Hand-written expectations for the default raster
      if (v[0]) begin
         for (int i = 0; i < 12; i++) begin
            if ((r[0] && tbl[i].k == -1) || (!r[0] && tbl[i].k == kk[0])) begin
               checks++;
               if ({d_en, d_x, d_y, d_act, d_hs, d_vs, d_nl, d_nf} !==
                   {tbl[i].en, tbl[i].x, tbl[i].y, tbl[i].act, tbl[i].hs, tbl[i].vs,
                    tbl[i].nl, tbl[i].nf}) begin
                  failures++;
                  $display("FAIL table[%0d] k=%0d got en=%b x=%0d y=%0d act=%b hs=%b vs=%b nl=%b nf=%b exp en=%b x=%0d y=%0d act=%b hs=%b vs=%b nl=%b nf=%b",
                           i, tbl[i].k, d_en, d_x, d_y, d_act, d_hs, d_vs, d_nl, d_nf,
                           tbl[i].en, tbl[i].x, tbl[i].y, tbl[i].act, tbl[i].hs, tbl[i].vs,
                           tbl[i].nl, tbl[i].nf);
               end
            end
         end
         if (!r[0] && kk[0] < 800 && d_hs == 1'b0) hs_low++;
         if (!r[0] && kk[0] == 800) check_val("hsync_low_cycles", 32'(hs_low), 32'd96);
      end
      if (failures >= 200) begin
         $display("FAIL too_many_failures got=%0d exp=0", failures);
         finish_tb();
      end
   end

   initial begin
      int n;
      bit ok;
      logic [1:0] sel;

      tbl[0]  = '{-1,  1'b0, 10'd0,   10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[1]  = '{0,   1'b1, 10'd0,   10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[2]  = '{1,   1'b1, 10'd1,   10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[3]  = '{639, 1'b1, 10'd639, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[4]  = '{640, 1'b1, 10'd640, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[5]  = '{655, 1'b1, 10'd655, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[6]  = '{656, 1'b1, 10'd656, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[7]  = '{751, 1'b1, 10'd751, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[8]  = '{752, 1'b1, 10'd752, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[9]  = '{799, 1'b1, 10'd799, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[10] = '{800, 1'b1, 10'd0,   10'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      tbl[11] = '{801, 1'b1, 10'd1,   10'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

      // Three reset cycles, then release everything together
      repeat (3) tick();
      rst_def = 1'b0; rst_sm = 1'b0; rst_hf = 1'b0;
      repeat (1000) tick();

      // Half rate: new_line only on the first of the two x=0 cycles
      ok = 1'b0;
      for (int i = 0; i < 400 && !ok; i++) begin
         tick();
         ok = (h_nl == 1'b1);
      end
      check_val("half_newline_seen", 32'(ok), 32'd1);
      if (ok) begin
         check_val("half_nl_x", 32'(h_x), 32'd0);
         check_val("half_nl_enable", 32'(h_en), 32'd0);
         tick();
         check_val("half_hold_x", 32'(h_x), 32'd0);
         check_val("half_hold_nl", 32'(h_nl), 32'd0);
         check_val("half_hold_enable", 32'(h_en), 32'd1);
      end

      // Mid-frame reset of the reduced raster
      ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         tick();
         ok = (s_x == 10'd5 && s_y == 10'd2);
      end
      check_val("midframe_pos_seen", 32'(ok), 32'd1);
      rst_sm = 1'b1;
      tick();
      check_val("rst_x", 32'(s_x), 32'd0);
      check_val("rst_y", 32'(s_y), 32'd0);
      check_val("rst_enable", 32'(s_en), 32'd0);
      check_val("rst_new_frame", 32'(s_nf), 32'd0);
      check_val("rst_new_line", 32'(s_nl), 32'd0);
      check_val("rst_frame_count", 32'(s_fc), 32'd0);
      check_val("rst_syncs_active", 32'({s_hs, s_vs, s_act}), 32'd7);
      rst_sm = 1'b0;
      tick();
      check_val("release_enable", 32'(s_en), 32'd1);
      check_val("release_x", 32'(s_x), 32'd0);
      check_val("release_no_strobe", 32'({s_nl, s_nf}), 32'd0);
      tick();
      check_val("release_x_step", 32'(s_x), 32'd1);

      // frame_count wrap 255 -> 0
      ok = 1'b0;
      for (int i = 0; i < 25000 && !ok; i++) begin
         tick();
         ok = (s_fc == 8'd255);
      end
      check_val("fc_reached_255", 32'(ok), 32'd1);
      ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         tick();
         ok = (s_nf == 1'b1);
      end
      check_val("wrap_new_frame_seen", 32'(ok), 32'd1);
      if (ok) begin
         check_val("wrap_frame_count", 32'(s_fc), 32'd0);
         check_val("wrap_pos", 32'({s_x, s_y}), 32'd0);
         check_val("wrap_new_line", 32'(s_nl), 32'd1);
         tick();
         check_val("wrap_nf_one_cycle", 32'(s_nf), 32'd0);
      end

      // Random reset storms on the reduced instances, checked by the model
      for (int it = 0; it < 30; it++) begin
         n = int'($urandom_range(20, 300));
         repeat (n) tick();
         sel = 2'($urandom_range(1, 3));
         if (sel[0]) rst_sm = 1'b1;
         if (sel[1]) rst_hf = 1'b1;
         n = int'($urandom_range(1, 3));
         repeat (n) tick();
         rst_sm = 1'b0;
         rst_hf = 1'b0;
      end
      repeat (300) tick();
      finish_tb();
   end

endmodule
